fifo_ctrl: RTL



---
 rtl/fifo_ctrl.sv | 64 ++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: single-clock FIFO pointer, occupancy, status and sticky error controller
module fifo_ctrl #(
  parameter int ADDR_WIDTH    = 6,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic                  write_ena,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  write_full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  logic [ADDR_WIDTH:0] wptr, rptr, count_next;
  logic wr_acc, rd_acc;
  // acceptance uses only registered flags; flush suppresses both sides
  always_comb begin
    wr_acc     = push & ~write_full & ~flush;
    rd_acc     = pop & ~empty & ~flush;
    write_ena  = wr_acc & rst_n;
    count_next = flush ? '0 :
                 (wr_acc & ~rd_acc) ? count + 1'b1 :
                 (rd_acc & ~wr_acc) ? count - 1'b1 : count;
  end
  assign write_addr = wptr[ADDR_WIDTH-1:0];
  assign read_addr  = rptr[ADDR_WIDTH-1:0];
  // pointers, occupancy, next-state status flags and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      write_full   <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= flush ? '0 : wptr + {{ADDR_WIDTH{1'b0}}, wr_acc};
      rptr         <= flush ? '0 : rptr + {{ADDR_WIDTH{1'b0}}, rd_acc};
      count        <= count_next;
      write_full   <= count_next == FULL_CNT;
      empty        <= count_next == '0;
      almost_full  <= count_next >= AF_CNT;
      almost_empty <= count_next <= AE_CNT;
      overflow     <= (push & write_full) | (overflow & ~err_clr);
      underflow    <= (pop & empty) | (underflow & ~err_clr);
    end
  end
endmodule
